stream_conditional_subtractor: RTL and testbench
================================================

// Module: stream_conditional_subtractor
// PURPOSE
//  Downstream of the chunk repeater. Takes a BITS_IN_NUM-bit value T and modulus N as
//  lockstep LSB-first REGISTER_SIZE chunk streams and computes D = T - N with a chunk borrow.
//  After the last chunk, replays D if T >= N, else T (final Montgomery reduction step).
//  The output handshake matches the repeater's, so stages chain directly.
// PARAMETERS
//  BITS_IN_NUM    4096  width of T, N and result; multiple of REGISTER_SIZE
//  REGISTER_SIZE  32    chunk width in bits
//  (NUM_BLOCKS = BITS_IN_NUM/REGISTER_SIZE, local; >= 2)
// PORTS
//  clk_in            in   1              one clock
//  rst_n_in          in   1              reset, asynchronous, active-low
//  t_in              in   REGISTER_SIZE  current chunk of T
//  n_in              in   REGISTER_SIZE  current chunk of N, aligned with t_in
//  data_valid_in     in   1              t_in/n_in hold a valid chunk (level)
//  consumed_out      out  1              chunk on t_in/n_in taken this cycle; upstream advances
//  data_out          out  REGISTER_SIZE  current result chunk, LSB chunk first
//  data_valid_out    out  1              data_out valid (level, whole EMIT phase)
//  consumed_in       in   1              downstream took data_out this cycle
//  subtracted_out    out  1              1 = stream is D (T>=N); valid while data_valid_out
// BEHAVIOUR
//  Reset (rst_n_in=0, async): state=LOAD; wr_idx, rd_idx, borrow, sel cleared;
//   consumed_out=0, data_valid_out=0, data_out=0, subtracted_out=0. Chunk buffers not cleared.
//  Storage: t_buf[NUM_BLOCKS], d_buf[NUM_BLOCKS] registers, each REGISTER_SIZE wide.
//  States:
//   LOAD:   consumed_out = data_valid_in (comb). On accept:
//           {b', d} = {1'b0,t_in} - {1'b0,n_in} - borrow  (REGISTER_SIZE+1 bits).
//           t_buf[wr_idx]<=t_in; d_buf[wr_idx]<=d; borrow<=b'; wr_idx++.
//           Accept at wr_idx==NUM_BLOCKS-1 -> DECIDE, wr_idx<=0.
//           Gaps (data_valid_in=0) hold all state.
//   DECIDE: one cycle. sel<=~borrow; borrow<=0; -> EMIT. consumed_out=0.
//   EMIT:   data_valid_out=1; data_out = sel ? d_buf[rd_idx] : t_buf[rd_idx] (comb from regs).
//           subtracted_out=sel. consumed_in=1 -> rd_idx++.
//           At rd_idx==NUM_BLOCKS-1 -> LOAD, rd_idx<=0.
//           consumed_in=0 holds data_out stable. Inputs ignored, consumed_out=0.
//  Outside EMIT: data_out=0, data_valid_out=0, subtracted_out=0. consumed_in ignored.
//  Latency: last chunk accepted in cycle k -> DECIDE k+1 -> data_valid_out=1 from k+2.
//  Throughput: one chunk per cycle each phase. No overlap of LOAD and EMIT.
//   Upstream sees consumed_out=0 for NUM_BLOCKS+1 cycles minimum.
//  T==N: borrow=0 -> D (all zero) emitted, subtracted_out=1.
//  Borrow carries across every chunk boundary. Final borrow is the only compare result.
//  Reset mid-LOAD/EMIT: partial data discarded. Next accepted chunk is chunk 0.
// TESTING (BITS_IN_NUM=128, REGISTER_SIZE=32, 4 chunks)
//  T=N=0x0123..CDEF, valid every cycle -> 4 chunks of 0, subtracted_out=1;
//   data_valid_out rises 2 cycles after 4th consumed_out.
//  T=5, N=7 -> output T (5,0,0,0), subtracted_out=0.
//  T=2^64, N=1 (borrow chain) -> 0xFFFFFFFF,0xFFFFFFFF,0,0; subtracted_out=1.
//  Random data_valid_in gaps and consumed_in stalls (random T,N, 1000 runs) -> results match
//   reference model; data_out stable while stalled; consumed_out only in LOAD.
//  rst_n_in pulsed low mid-EMIT (after 2 chunks consumed) -> outputs 0 immediately (async);
//   next operation T=9, N=4 -> output 5,0,0,0.
//  Back-to-back numbers: second T streamed right after first EMIT ends.
//   -> no chunk loss; borrow cleared between numbers.

Source files
------------

// File: rtl/stream_conditional_subtractor_if.sv
// rtl/stream_conditional_subtractor_if.sv - chunk stream handshake bundle for the conditional subtractor
`timescale 1ns/1ps
interface stream_conditional_subtractor_if #(
  parameter int REGISTER_SIZE = 32
);
  logic [REGISTER_SIZE-1:0] t_in;
  logic [REGISTER_SIZE-1:0] n_in;
  logic                     data_valid_in;
  logic                     consumed_out;
  logic [REGISTER_SIZE-1:0] data_out;
  logic                     data_valid_out;
  logic                     consumed_in;
  logic                     subtracted_out;

  modport slave (
    input  t_in, n_in, data_valid_in, consumed_in,
    output consumed_out, data_out, data_valid_out, subtracted_out
  );

  modport master (
    output t_in, n_in, data_valid_in, consumed_in,
    input  consumed_out, data_out, data_valid_out, subtracted_out
  );
endinterface

// File: rtl/stream_conditional_subtractor.sv
// rtl/stream_conditional_subtractor.sv - chunked T-N with final borrow select, replays D or T
`timescale 1ns/1ps
module stream_conditional_subtractor #(
  parameter int BITS_IN_NUM   = 4096,
  parameter int REGISTER_SIZE = 32
) (
  input logic                          clk_in,
  input logic                          rst_n_in,
  stream_conditional_subtractor_if.slave bus
);
  localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int IDX_W      = $clog2(NUM_BLOCKS);

  typedef enum logic [1:0] {ST_LOAD, ST_DECIDE, ST_EMIT} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [IDX_W-1:0]         wr_idx;
  logic [IDX_W-1:0]         rd_idx;
  logic                     borrow;
  logic                     sel;
  logic [REGISTER_SIZE-1:0] t_buf [NUM_BLOCKS];
  logic [REGISTER_SIZE-1:0] d_buf [NUM_BLOCKS];
  logic [REGISTER_SIZE:0]   diff;
  logic                     accept;
  logic                     last_wr;
  logic                     last_rd;
  logic                     take;

  // Top bit of the widened difference is the borrow into the next chunk.
  assign diff    = {1'b0, bus.t_in} - {1'b0, bus.n_in} - {{REGISTER_SIZE{1'b0}}, borrow};
  assign accept  = (state == ST_LOAD) && bus.data_valid_in;
  assign take    = (state == ST_EMIT) && bus.consumed_in;
  assign last_wr = (wr_idx == IDX_W'(NUM_BLOCKS - 1));
  assign last_rd = (rd_idx == IDX_W'(NUM_BLOCKS - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next         = state;
    bus.consumed_out   = 1'b0;
    bus.data_valid_out = 1'b0;
    bus.data_out       = '0;
    bus.subtracted_out = 1'b0;
    case (state)
      ST_LOAD: begin
        bus.consumed_out = bus.data_valid_in && rst_n_in;
        if (bus.data_valid_in && last_wr) begin
          state_next = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        state_next = ST_EMIT;
      end
      ST_EMIT: begin
        bus.data_valid_out = 1'b1;
        bus.data_out       = sel ? d_buf[rd_idx] : t_buf[rd_idx];
        bus.subtracted_out = sel;
        if (bus.consumed_in && last_rd) begin
          state_next = ST_LOAD;
        end
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_idx <= '0;
      rd_idx <= '0;
      borrow <= 1'b0;
      sel    <= 1'b0;
    end else begin
      if (accept) begin
        borrow <= diff[REGISTER_SIZE];
        wr_idx <= last_wr ? '0 : wr_idx + IDX_W'(1);
      end
      if (state == ST_DECIDE) begin
        sel    <= ~borrow;
        borrow <= 1'b0;
      end
      if (take) begin
        rd_idx <= last_rd ? '0 : rd_idx + IDX_W'(1);
      end
    end
  end

  // Chunk buffers carry no reset; they are always rewritten before being read.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      t_buf[wr_idx] <= bus.t_in;
      d_buf[wr_idx] <= diff[REGISTER_SIZE-1:0];
    end
  end
endmodule

// File: tb/tb_stream_conditional_subtractor.sv
// tb/tb_stream_conditional_subtractor.sv - self-checking bench for stream_conditional_subtractor
`timescale 1ns/1ps
module tb_stream_conditional_subtractor;
  localparam int BITS = 128;
  localparam int REG  = 32;
  localparam int NB   = BITS / REG;

  logic clk_in = 1'b0;
  logic rst_n_in;
  always #5 clk_in = ~clk_in;

  stream_conditional_subtractor_if #(.REGISTER_SIZE(REG)) bus ();

  stream_conditional_subtractor #(
    .BITS_IN_NUM  (BITS),
    .REGISTER_SIZE(REG)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [BITS-1:0] t;
    logic [BITS-1:0] n;
    logic [BITS-1:0] res;
    logic            sub;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Streams all chunks of one number; accepted whenever valid is driven.
  task automatic load_number(input logic [BITS-1:0] t, input logic [BITS-1:0] n, input int gap_pct);
    int   i;
    int   guard;
    logic v;
    i = 0;
    guard = 0;
    while (i < NB && guard < 400) begin
      v = ($urandom_range(99) >= gap_pct);
      bus.t_in          = v ? t[i*REG +: REG] : $urandom;
      bus.n_in          = v ? n[i*REG +: REG] : $urandom;
      bus.data_valid_in = v;
      bus.consumed_in   = $urandom_range(1);
      #2;
      check("load_consumed", bus.consumed_out, v);
      check("load_valid_out", bus.data_valid_out, 0);
      check("load_data_out", bus.data_out, 0);
      if (v) i++;
      tick();
      guard++;
    end
    check("load_timeout", i, NB);
    bus.data_valid_in = 1'b0;
  endtask

  task automatic decide_check();
    bus.data_valid_in = 1'b1;
    bus.consumed_in   = 1'b1;
    bus.t_in          = $urandom;
    bus.n_in          = $urandom;
    #2;
    check("decide_consumed", bus.consumed_out, 0);
    check("decide_valid_out", bus.data_valid_out, 0);
    tick();
    bus.data_valid_in = 1'b0;
  endtask

  task automatic emit_number(input int stall_pct, output logic [BITS-1:0] res, output logic sub);
    int              j;
    int              guard;
    logic            c;
    logic            stalled;
    logic [REG-1:0]  prev;
    j = 0;
    guard = 0;
    stalled = 1'b0;
    prev = '0;
    res = '0;
    sub = 1'b0;
    while (j < NB && guard < 400) begin
      c = ($urandom_range(99) >= stall_pct);
      bus.consumed_in   = c;
      bus.data_valid_in = $urandom_range(1);
      bus.t_in          = $urandom;
      bus.n_in          = $urandom;
      #2;
      check("emit_valid_out", bus.data_valid_out, 1);
      check("emit_consumed_out", bus.consumed_out, 0);
      if (stalled) check("emit_stall_stable", bus.data_out, prev);
      if (c) begin
        res[j*REG +: REG] = bus.data_out;
        j++;
      end
      sub     = bus.subtracted_out;
      stalled = !c;
      prev    = bus.data_out;
      tick();
      guard++;
    end
    check("emit_timeout", j, NB);
    bus.consumed_in   = 1'b0;
    bus.data_valid_in = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [BITS-1:0] t, input logic [BITS-1:0] n,
                        input int gap_pct, input int stall_pct,
                        input logic [BITS-1:0] exp_res, input logic exp_sub);
    logic [BITS-1:0] res;
    logic            sub;
    load_number(t, n, gap_pct);
    decide_check();
    emit_number(stall_pct, res, sub);
    check({name, "_data"}, res, exp_res);
    check({name, "_sub"}, sub, exp_sub);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [BITS-1:0] t;
    logic [BITS-1:0] n;
    logic [BITS-1:0] exp_res;
    logic            exp_sub;

    vecs[0] = '{t: 128'h0123456789ABCDEF0123456789ABCDEF, n: 128'h0123456789ABCDEF0123456789ABCDEF,
                res: 128'h0, sub: 1'b1};
    vecs[1] = '{t: 128'd5, n: 128'd7, res: 128'd5, sub: 1'b0};
    vecs[2] = '{t: 128'h0000000000000001_0000000000000000, n: 128'd1,
                res: 128'h0000000000000000_FFFFFFFFFFFFFFFF, sub: 1'b1};
    vecs[3] = '{t: 128'd9, n: 128'd4, res: 128'd5, sub: 1'b1};
    vecs[4] = '{t: 128'h0, n: {BITS{1'b1}}, res: 128'h0, sub: 1'b0};
    vecs[5] = '{t: {BITS{1'b1}}, n: 128'h0, res: {BITS{1'b1}}, sub: 1'b1};
    vecs[6] = '{t: 128'h80000000_00000000_00000000_00000000, n: 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                res: 128'd1, sub: 1'b1};
    vecs[7] = '{t: 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, n: 128'h80000000_00000000_00000000_00000000,
                res: 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, sub: 1'b0};

    rst_n_in          = 1'b0;
    bus.t_in          = '0;
    bus.n_in          = '0;
    bus.data_valid_in = 1'b1;
    bus.consumed_in   = 1'b1;
    repeat (2) @(posedge clk_in);
    #3;
    check("reset_consumed", bus.consumed_out, 0);
    check("reset_valid_out", bus.data_valid_out, 0);
    check("reset_data_out", bus.data_out, 0);
    check("reset_sub", bus.subtracted_out, 0);
    bus.data_valid_in = 1'b0;
    bus.consumed_in   = 1'b0;
    tick();
    rst_n_in = 1'b1;

    // Directed table, run back to back with no idle cycles between numbers.
    for (int k = 0; k < 8; k++) begin
      run_op($sformatf("vec%0d", k), vecs[k].t, vecs[k].n, 0, 0, vecs[k].res, vecs[k].sub);
    end

    // Reset during LOAD after two chunks: the partial number is dropped.
    bus.data_valid_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.t_in = 32'hAAAA_0000 + k;
      bus.n_in = 32'h1;
      tick();
    end
    bus.data_valid_in = 1'b0;
    rst_n_in = 1'b0;
    #1;
    check("rst_load_valid_out", bus.data_valid_out, 0);
    check("rst_load_consumed", bus.consumed_out, 0);
    tick();
    rst_n_in = 1'b1;
    run_op("after_load_rst", 128'd9, 128'd4, 0, 0, 128'd5, 1'b1);

    // Reset during EMIT after two chunks consumed: outputs drop without a clock edge.
    load_number({BITS{1'b1}}, 128'd1, 0);
    decide_check();
    bus.consumed_in = 1'b1;
    tick();
    tick();
    bus.consumed_in = 1'b0;
    #2;
    check("pre_rst_emit_valid", bus.data_valid_out, 1);
    rst_n_in = 1'b0;
    #1;
    check("rst_emit_valid_out", bus.data_valid_out, 0);
    check("rst_emit_data_out", bus.data_out, 0);
    check("rst_emit_sub", bus.subtracted_out, 0);
    tick();
    rst_n_in = 1'b1;
    run_op("after_emit_rst", 128'd9, 128'd4, 0, 0, 128'd5, 1'b1);

    // Randomized numbers with input gaps and output stalls against an arithmetic model.
    for (int r = 0; r < 1000; r++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(7))
        0: n = t;
        1: n = t + 128'($urandom_range(3));
        2: n = t - 128'($urandom_range(3));
        default: n = {$urandom, $urandom, $urandom, $urandom};
      endcase
      exp_sub = (t >= n);
      exp_res = exp_sub ? (t - n) : t;
      run_op("rand", t, n, $urandom_range(50), $urandom_range(50), exp_res, exp_sub);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
